cp0_irq_ctrl: RTL
=================

# cp0_irq_ctrl

Parametrised Coprocessor 0 for the MipsCore: it holds COUNT/COMPARE/SR/CAUSE/EPC and takes the exception handshake from the pipeline. It adds a configurable count prescaler, N_HWINT level-sensitive external interrupt lines and two software interrupts. Interrupts are gated by a per-source mask (SR.IM), SR.IE and SR.EXL. It sits beside the ID/EX stages and drives the fetch redirect (EXC_OCCUR/EXC_NPC).

## Interface
- CNT_DIV, 1024: CLK cycles per COUNT increment (≥1).
- N_HWINT, 2: external interrupt lines (1..5), mapped to CAUSE.IP[2+k].
- ADDR_W, 32: width of EPC, EXC_EPC and EXC_NPC.
- EXC_VECTOR, 'h100: exception entry address.
- CLK  in  1  clock.
- RST_X  in  1  asynchronous, active-low reset.
- REG_NUM  in  5  CP0 register select for read and write.
- REG_IN  in  32  write data (mtc0).
- REG_WE  in  1  write enable.
- REG_OUT  out  32  registered read data (mfc0).
- HW_INT  in  N_HWINT  asynchronous level interrupt requests.
- EXC_SET  in  1  synchronous exception request from the pipeline.
- EXC_CODE  in  5  cause code for EXC_SET.
- EXC_EPC  in  ADDR_W  restart PC of the faulting or interrupted instruction.
- EXC_BD  in  1  that instruction is in a branch delay slot.
- EXC_ACK  in  1  pipeline has flushed and taken the redirect.
- EXC_CLR  in  1  eret executed.
- EXC_OCCUR  out  1  redirect request to fetch.
- EXC_NPC  out  ADDR_W  redirect target.

## Operation
- Register map:
  - 9 COUNT (r/w).
  - 11 COMPARE (r/w).
  - 12 SR: bit0 IE, bit1 EXL, [15:8] IM; other bits read 0 and ignore writes.
  - 13 CAUSE: bit31 BD, [15:8] IP, [6:2] ExcCode. Only IP[1:0] (software interrupts) are writable.
  - 14 EPC (r/w, low ADDR_W bits; upper bits read 0).
  - Any other number reads 0.
- HW_INT passes through a 2-flop synchroniser. IP[2+k] is the live synchronised level, read-only. Unused IP bits read 0.
- Prescaler counts 0..CNT_DIV-1; COUNT increments when it wraps. COUNT wraps 0xFFFFFFFF→0.
- IP[7] (timer) sets when an increment makes COUNT equal to COMPARE. It is sticky and clears only on a COMPARE write.
- Writing COUNT loads the value and zeroes the prescaler.
- irq = |(IP & IM) & IE & ~EXL.
- State machine:
  - IDLE → PEND on EXC_SET or irq:
    - EXC_OCCUR←1, EXC_NPC←EXC_VECTOR.
    - ExcCode←EXC_CODE if EXC_SET, else 0.
    - EXC_SET has priority over irq.
  - PEND → HANDLER on EXC_ACK:
    - EXC_OCCUR←0, SR.EXL←1.
    - If EXL was 0: EPC←EXC_EPC and CAUSE.BD←EXC_BD. If EXL was already 1, EPC and BD are kept.
  - HANDLER → IDLE on EXC_CLR: EXL←0, EXC_NPC←EPC. EXC_OCCUR is not raised; the pipeline's eret redirects using EXC_NPC.
  - HANDLER → PEND on EXC_SET (nested synchronous exception). irq is masked by EXL.
  - In IDLE, EXC_ACK and EXC_CLR are ignored. In PEND, EXC_CLR is ignored.
- Same-cycle priority: EXC_SET/irq entry > EXC_ACK > EXC_CLR > REG_WE. A REG_WE colliding with a higher event is dropped.
- A COMPARE write and a timer match in the same cycle: the write wins and IP[7] ends 0.
- Reset values:
  - All registers, prescaler and synchroniser are 0.
  - State is IDLE.
  - EXC_OCCUR=0, EXC_NPC=0, REG_OUT=0.

## Timing
- REG_OUT = value of register REG_NUM one cycle after REG_NUM is presented. A write at edge t is visible in REG_OUT at t+1 when the read is presented at t+1.
- HW_INT to IP visible: 2 cycles. IP to EXC_OCCUR: +1 cycle.
- EXC_SET sampled at edge t → EXC_OCCUR=1 after edge t. It stays high until the edge that samples EXC_ACK.
- Timer: IP[7] sets at the same edge COUNT reaches COMPARE. EXC_OCCUR follows one edge later if the interrupt is enabled.
- Async reset takes effect immediately in any state. A pending redirect is abandoned.

## Test plan
- Reset mid-PEND (EXC_OCCUR=1), release → all outputs 0, SR=0, CAUSE=0, state IDLE; a read of reg 12 returns 0.
- CNT_DIV=4, COMPARE=3, SR=0x8001 → COUNT=3 at cycle 12, IP[7]=1. Then EXC_OCCUR=1, EXC_NPC=0x100, ExcCode=0. ACK with EXC_EPC=0x2000 → EPC=0x2000, EXL=1. Writing COMPARE clears IP[7].
- HW_INT[0] high, SR.IM[2]=1, IE=1 → EXC_OCCUR rises 3 cycles later. Clearing IM[2] before the request is raised prevents entry.
- EXC_SET (code 8) and a pending irq in the same cycle → ExcCode=8. After ACK and CLR, the irq is taken next with ExcCode=0.
- Nested: in HANDLER (EPC=0x40), EXC_SET with EXC_EPC=0x80 and ACK → EPC stays 0x40, BD unchanged. EXC_CLR → EXC_NPC=0x40, EXL=0.
- Write CAUSE=0xFFFFFFFF → reads back 0x00000300 (only IP[1:0]) with no HW/timer sources. Set IM[0] and IE → software interrupt taken.

Source files
------------

// File: rtl/cp0_irq_ctrl.sv
// Coprocessor 0 for the MipsCore: COUNT/COMPARE timer, SR/CAUSE/EPC,
// interrupt gating and the exception/eret handshake with the pipeline.
module cp0_irq_ctrl #(
    parameter int unsigned CNT_DIV = 1024,
    parameter int unsigned N_HWINT = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = 'h100
) (
    input  logic                CLK,
    input  logic                RST_X,
    input  logic [4:0]          REG_NUM,
    input  logic [31:0]         REG_IN,
    input  logic                REG_WE,
    output logic [31:0]         REG_OUT,
    input  logic [N_HWINT-1:0]  HW_INT,
    input  logic                EXC_SET,
    input  logic [4:0]          EXC_CODE,
    input  logic [ADDR_W-1:0]   EXC_EPC,
    input  logic                EXC_BD,
    input  logic                EXC_ACK,
    input  logic                EXC_CLR,
    output logic                EXC_OCCUR,
    output logic [ADDR_W-1:0]   EXC_NPC
);

    localparam int unsigned PW = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;

    typedef enum logic [1:0] {IDLE, PEND, HANDLER} state_t;
    state_t state, state_nx;

    logic [PW-1:0]      presc;
    logic [31:0]        count, compare;
    logic               sr_ie, sr_exl;
    logic [7:0]         sr_im;
    logic               cause_bd;
    logic [1:0]         ip_sw;
    logic               ip_timer;
    logic [4:0]         exc_code;
    logic [ADDR_W-1:0]  epc;
    logic [N_HWINT-1:0] hw_meta, hw_sync;

    logic [7:0]  ip;
    logic        irq, tick, wr, timer_match;
    logic        take_exc, do_ack, do_clr;
    logic [31:0] rd_data;

    always_comb begin
        ip = '0;
        ip[1:0] = ip_sw;
        ip[2 +: N_HWINT] = hw_sync;
        ip[7] = ip_timer;
    end

    assign irq  = (|(ip & sr_im)) & sr_ie & ~sr_exl;
    assign tick = (presc == PW'(CNT_DIV - 1));

    always_comb begin
        state_nx = state;
        take_exc = 1'b0;
        do_ack   = 1'b0;
        do_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (EXC_SET || irq) begin
                    take_exc = 1'b1;
                    state_nx = PEND;
                end
            end
            PEND: begin
                if (EXC_ACK) begin
                    do_ack   = 1'b1;
                    state_nx = HANDLER;
                end
            end
            HANDLER: begin
                if (EXC_SET) begin
                    take_exc = 1'b1;
                    state_nx = PEND;
                end else if (EXC_CLR) begin
                    do_clr   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // A register write loses to any handshake event in the same cycle.
    assign wr = REG_WE & ~take_exc & ~do_ack & ~do_clr;
    assign timer_match = tick && !(wr && REG_NUM == 5'd9) && (count + 32'd1 == compare);

    always_comb begin
        rd_data = '0;
        case (REG_NUM)
            5'd9:    rd_data = count;
            5'd11:   rd_data = compare;
            5'd12:   rd_data = {16'b0, sr_im, 6'b0, sr_exl, sr_ie};
            5'd13:   rd_data = {cause_bd, 15'b0, ip, 1'b0, exc_code, 2'b0};
            5'd14:   rd_data[ADDR_W-1:0] = epc;
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            presc     <= '0;
            count     <= '0;
            compare   <= '0;
            sr_ie     <= 1'b0;
            sr_exl    <= 1'b0;
            sr_im     <= '0;
            cause_bd  <= 1'b0;
            ip_sw     <= '0;
            ip_timer  <= 1'b0;
            exc_code  <= '0;
            epc       <= '0;
            hw_meta   <= '0;
            hw_sync   <= '0;
            EXC_OCCUR <= 1'b0;
            EXC_NPC   <= '0;
            REG_OUT   <= '0;
        end else begin
            hw_meta <= HW_INT;
            hw_sync <= hw_meta;
            REG_OUT <= rd_data;

            if (wr && REG_NUM == 5'd9) begin
                count <= REG_IN;
                presc <= '0;
            end else begin
                presc <= tick ? '0 : presc + PW'(1);
                if (tick) count <= count + 32'd1;
            end

            if (wr && REG_NUM == 5'd11) begin
                compare  <= REG_IN;
                ip_timer <= 1'b0;
            end else if (timer_match) begin
                ip_timer <= 1'b1;
            end

            if (wr && REG_NUM == 5'd12) begin
                sr_ie  <= REG_IN[0];
                sr_exl <= REG_IN[1];
                sr_im  <= REG_IN[15:8];
            end
            if (wr && REG_NUM == 5'd13) ip_sw <= REG_IN[9:8];
            if (wr && REG_NUM == 5'd14) epc <= REG_IN[ADDR_W-1:0];

            if (take_exc) begin
                EXC_OCCUR <= 1'b1;
                EXC_NPC   <= EXC_VECTOR;
                exc_code  <= EXC_SET ? EXC_CODE : 5'd0;
            end
            // Nested entry (EXL already set) keeps the outer EPC/BD.
            if (do_ack) begin
                EXC_OCCUR <= 1'b0;
                sr_exl    <= 1'b1;
                if (!sr_exl) begin
                    epc      <= EXC_EPC;
                    cause_bd <= EXC_BD;
                end
            end
            if (do_clr) begin
                sr_exl  <= 1'b0;
                EXC_NPC <= epc;
            end
        end
    end

endmodule
